interval_timer: RTL and testbench

//  Programmable interval/tick generator for the micro-processor test platform. Counts clk cycles over
//  a run-time adjustable period and pulses tick on the last cycle of each period. Runs one-shot or

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_if.sv | 31 +++
 rtl/timer_edge_det.sv | 19 +
 rtl/interval_timer.sv | 107 ++++++++++
 tb/tb_interval_timer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding and default timing constants for the interval timer.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  localparam int CNT_W_C      = 32;
  localparam int DEF_PERIOD_C = 50_000_000;
  localparam int MIN_PERIOD_C = 5_000_000;
  localparam int MAX_PERIOD_C = 50_000_000;
  localparam int STEP_C       = 5_000_000;
  localparam int CMP_LO_C     = 2_000_000;
  localparam int CMP_HI_C     = 25_000_000;

endpackage

// File: rtl/timer_if.sv
// Control/status bundle of the interval timer; the irq pair exists only when
// TIMER_STICKY_IRQ_EN is defined.
`timescale 1ns/1ps
interface timer_if #(parameter int CNT_W = 32);
  logic             clr;
  logic             strtcntr;
  logic             Loop;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic             tick;
  logic             busy;
  logic             done;
  logic             cmp_ge_lo;
  logic             cmp_le_hi;
`ifdef TIMER_STICKY_IRQ_EN
  logic             irq_ack;
  logic             irq;

  modport master (output clr, strtcntr, Loop, inc, dec, irq_ack,
                  input  count, period, tick, busy, done, cmp_ge_lo, cmp_le_hi, irq);
  modport slave  (input  clr, strtcntr, Loop, inc, dec, irq_ack,
                  output count, period, tick, busy, done, cmp_ge_lo, cmp_le_hi, irq);
`else
  modport master (output clr, strtcntr, Loop, inc, dec,
                  input  count, period, tick, busy, done, cmp_ge_lo, cmp_le_hi);
  modport slave  (input  clr, strtcntr, Loop, inc, dec,
                  output count, period, tick, busy, done, cmp_ge_lo, cmp_le_hi);
`endif
endinterface

// File: rtl/timer_edge_det.sv
// One-bit rising-edge detector; rise is high for the first cycle d is seen high.
`timescale 1ns/1ps
module timer_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/interval_timer.sv
// Programmable interval/tick generator with one-shot/loop modes and clamped
// inc/dec period adjust. Optional sticky irq when TIMER_STICKY_IRQ_EN is defined.
`timescale 1ns/1ps
module interval_timer
  import timer_pkg::*;
#(
  parameter int CNT_W      = CNT_W_C,
  parameter int DEF_PERIOD = DEF_PERIOD_C,
  parameter int MIN_PERIOD = MIN_PERIOD_C,
  parameter int MAX_PERIOD = MAX_PERIOD_C,
  parameter int STEP       = STEP_C,
  parameter int CMP_LO     = CMP_LO_C,
  parameter int CMP_HI     = CMP_HI_C
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);

  localparam int W1 = CNT_W + 1;
  localparam logic [CNT_W:0] STEP_W = W1'(STEP);
  localparam logic [CNT_W:0] MIN_W  = W1'(MIN_PERIOD);
  localparam logic [CNT_W:0] MAX_W  = W1'(MAX_PERIOD);
  localparam logic [CNT_W:0] ONE_W  = W1'(1);

  if (MIN_PERIOD < 1 || MIN_PERIOD > DEF_PERIOD || DEF_PERIOD > MAX_PERIOD) begin : g_bad_cfg
    $error("interval_timer: need 1 <= MIN_PERIOD <= DEF_PERIOD <= MAX_PERIOD");
  end

  timer_state_e     state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period;
  logic             incRise;
  logic             decRise;
  logic             tick;
  logic [CNT_W:0]   incSum;

  timer_edge_det u_inc_edge (.clk(clk), .reset(reset), .d(bus.inc), .rise(incRise));
  timer_edge_det u_dec_edge (.clk(clk), .reset(reset), .d(bus.dec), .rise(decRise));

  // count+1 >= period avoids the period-1 underflow and still fires when a
  // shrinking period lands below the running count.
  assign tick   = (state == RUN) && (({1'b0, count} + ONE_W) >= {1'b0, period});
  assign incSum = {1'b0, period} + STEP_W;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else if (bus.clr) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          count <= '0;
          if (bus.strtcntr) state <= RUN;
        end
        RUN: begin
          if (tick) begin
            count <= '0;
            state <= bus.Loop ? RUN : DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period <= CNT_W'(DEF_PERIOD);
    end else if (incRise && !decRise) begin
      period <= (incSum <= MAX_W) ? incSum[CNT_W-1:0] : CNT_W'(MAX_PERIOD);
    end else if (decRise && !incRise) begin
      period <= ({1'b0, period} >= (MIN_W + STEP_W)) ? (period - CNT_W'(STEP))
                                                     : CNT_W'(MIN_PERIOD);
    end
  end

`ifdef TIMER_STICKY_IRQ_EN
  logic irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           irq <= 1'b0;
    else if (bus.clr)     irq <= 1'b0;
    else if (tick)        irq <= 1'b1;
    else if (bus.irq_ack) irq <= 1'b0;
  end

  assign bus.irq = irq;
`endif

  assign bus.count     = count;
  assign bus.period    = period;
  assign bus.tick      = tick;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.cmp_ge_lo = (count >= CNT_W'(CMP_LO));
  assign bus.cmp_le_hi = (count <= CNT_W'(CMP_HI));

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer using small sim periods.
`timescale 1ns/1ps
module tb_interval_timer;

  logic clk;
  logic reset;
  int   compareCount;
  int   mismatchCount;

  timer_if #(.CNT_W(32)) bus ();

  interval_timer #(
    .CNT_W(32), .DEF_PERIOD(10), .MIN_PERIOD(4), .MAX_PERIOD(10),
    .STEP(2), .CMP_LO(3), .CMP_HI(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic strt, input logic loopMode, input logic incIn,
                               input logic decIn, input logic clrIn);
    bus.strtcntr = strt;
    bus.Loop     = loopMode;
    bus.inc      = incIn;
    bus.dec      = decIn;
    bus.clr      = clrIn;
  endtask

  task automatic advanceCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One button press: high for a cycle, then released for a cycle.
  task automatic pressButton(input logic loopMode, input logic incIn, input logic decIn);
    applyStimulus(1'b0, loopMode, incIn, decIn, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, loopMode, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
  endtask

  initial begin
    int cnt;
    compareCount  = 0;
    mismatchCount = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TIMER_STICKY_IRQ_EN
    bus.irq_ack = 1'b0;
`endif
    advanceCycles(2);

    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_period", bus.period, 10);
    checkOutput("rst_busy", {31'd0, bus.busy}, 0);
    checkOutput("rst_done", {31'd0, bus.done}, 0);
    checkOutput("rst_tick", {31'd0, bus.tick}, 0);
    checkOutput("rst_ge_lo", {31'd0, bus.cmp_ge_lo}, 0);
    checkOutput("rst_le_hi", {31'd0, bus.cmp_le_hi}, 1);
    reset = 1'b1;
    advanceCycles(1);

    // Loop mode: count 0..9 repeating, tick on 9.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cnt = i % 10;
      checkOutput("loop_count", bus.count, cnt);
      checkOutput("loop_tick", {31'd0, bus.tick}, (cnt == 9) ? 1 : 0);
      checkOutput("loop_busy", {31'd0, bus.busy}, 1);
      checkOutput("loop_ge_lo", {31'd0, bus.cmp_ge_lo}, (cnt >= 3) ? 1 : 0);
      checkOutput("loop_le_hi", {31'd0, bus.cmp_le_hi}, (cnt <= 6) ? 1 : 0);
      advanceCycles(1);
    end

    // One-shot run then re-arm from DONE.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_busy", {31'd0, bus.busy}, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("os_start_count", bus.count, 0);
    advanceCycles(9);
    checkOutput("os_count9", bus.count, 9);
    checkOutput("os_tick", {31'd0, bus.tick}, 1);
    advanceCycles(1);
    checkOutput("os_done", {31'd0, bus.done}, 1);
    checkOutput("os_busy", {31'd0, bus.busy}, 0);
    checkOutput("os_count0", bus.count, 0);
    checkOutput("os_tick_off", {31'd0, bus.tick}, 0);
    advanceCycles(3);
    checkOutput("os_done_hold", {31'd0, bus.done}, 1);
    checkOutput("os_count_hold", bus.count, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rerun_busy", {31'd0, bus.busy}, 1);
    checkOutput("rerun_done", {31'd0, bus.done}, 0);
    advanceCycles(1);
    checkOutput("rerun_count", bus.count, 1);

    // Period adjust with clamping.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pressButton(1'b0, 1'b0, 1'b1); checkOutput("dec1", bus.period, 8);
    pressButton(1'b0, 1'b0, 1'b1); checkOutput("dec2", bus.period, 6);
    pressButton(1'b0, 1'b0, 1'b1); checkOutput("dec3", bus.period, 4);
    pressButton(1'b0, 1'b0, 1'b1); checkOutput("dec4_clamp", bus.period, 4);
    pressButton(1'b0, 1'b1, 1'b0); checkOutput("inc1", bus.period, 6);
    pressButton(1'b0, 1'b1, 1'b0); checkOutput("inc2", bus.period, 8);
    pressButton(1'b0, 1'b1, 1'b0); checkOutput("inc3", bus.period, 10);
    pressButton(1'b0, 1'b1, 1'b0); checkOutput("inc4_clamp", bus.period, 10);
    pressButton(1'b0, 1'b0, 1'b1); checkOutput("dec_to8", bus.period, 8);
    pressButton(1'b0, 1'b1, 1'b1); checkOutput("both_hold", bus.period, 8);
    pressButton(1'b0, 1'b1, 1'b0); checkOutput("inc_to10", bus.period, 10);

    // Shrink the period below the running count.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(3);
    checkOutput("shr_count3", bus.count, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    checkOutput("shr_period8", bus.period, 8);
    checkOutput("shr_count5", bus.count, 5);
    checkOutput("shr_notick", {31'd0, bus.tick}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    advanceCycles(1);
    checkOutput("shr_period6", bus.period, 6);
    checkOutput("shr_count6", bus.count, 6);
    checkOutput("shr_tick", {31'd0, bus.tick}, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    checkOutput("shr_wrap", bus.count, 0);
    checkOutput("shr_busy", {31'd0, bus.busy}, 1);

    // clr mid-run beats strtcntr.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressButton(1'b1, 1'b1, 1'b0);
    pressButton(1'b1, 1'b1, 1'b0);
    checkOutput("clr_period10", bus.period, 10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(5);
    checkOutput("clr_pre_count", bus.count, 5);
    checkOutput("clr_pre_ge_lo", {31'd0, bus.cmp_ge_lo}, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    advanceCycles(1);
    checkOutput("clr_count", bus.count, 0);
    checkOutput("clr_busy2", {31'd0, bus.busy}, 0);
    checkOutput("clr_ge_lo", {31'd0, bus.cmp_ge_lo}, 0);
    checkOutput("clr_le_hi", {31'd0, bus.cmp_le_hi}, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(2);
    checkOutput("clr_stay_idle", {31'd0, bus.busy}, 0);
    checkOutput("clr_stay_count", bus.count, 0);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pressButton(1'b1, 1'b0, 1'b1);
    checkOutput("ar_pre_period", bus.period, 8);
    checkOutput("ar_pre_count", bus.count, 2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_count", bus.count, 0);
    checkOutput("ar_period", bus.period, 10);
    checkOutput("ar_busy", {31'd0, bus.busy}, 0);
    checkOutput("ar_done", {31'd0, bus.done}, 0);
    checkOutput("ar_tick", {31'd0, bus.tick}, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    advanceCycles(1);
    checkOutput("ar_after_busy", {31'd0, bus.busy}, 0);

`ifdef TIMER_STICKY_IRQ_EN
    // Sticky irq: set on tick, held until ack, set wins over ack.
    checkOutput("irq_rst", {31'd0, bus.irq}, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    advanceCycles(9);
    checkOutput("irq_tick", {31'd0, bus.tick}, 1);
    checkOutput("irq_pre", {31'd0, bus.irq}, 0);
    advanceCycles(1);
    checkOutput("irq_set", {31'd0, bus.irq}, 1);
    advanceCycles(3);
    checkOutput("irq_hold", {31'd0, bus.irq}, 1);
    bus.irq_ack = 1'b1;
    advanceCycles(1);
    checkOutput("irq_ack", {31'd0, bus.irq}, 0);
    advanceCycles(5);
    checkOutput("irq_ack_count", bus.count, 9);
    advanceCycles(1);
    checkOutput("irq_set_wins", {31'd0, bus.irq}, 1);
    bus.irq_ack = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
